// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM test sequencer: bus widths, sequencer
// states and the data-pattern mode codes.
package sram_test_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_WAIT  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [1:0] MODE_ADDR    = 2'd0;
    localparam logic [1:0] MODE_CHECKER = 2'd1;
    localparam logic [1:0] MODE_SOLID   = 2'd2;
    localparam logic [1:0] MODE_HASH    = 2'd3;

endpackage

// File: rtl/sram_test_pattern.sv
// Expected-data generator: maps an address to the byte the test writes there
// and later expects to read back, for the selected pattern mode and seed.
module sram_test_pattern
    import sram_test_pkg::*;
(
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] exp
);

    logic [2:0] w_unusedAddrHi;
    assign w_unusedAddrHi = addr[ADDR_W-1:16];

    // Pattern selection; every pattern is finally XORed with the seed.
    always_comb begin
        exp = '0;
        case (mode)
            MODE_ADDR:    exp = addr[7:0] ^ seed;
            MODE_CHECKER: exp = (addr[0] ? 8'hAA : 8'h55) ^ seed;
            MODE_SOLID:   exp = seed;
            MODE_HASH:    exp = ~(addr[7:0] ^ addr[15:8]) ^ seed;
            default:      exp = seed;
        endcase
    end

endmodule

// File: rtl/sram_test_seq.sv
// SRAM test sequencer: writes a pattern to addresses 0..LAST_ADDR, reads it
// back through the SRAM controller, counts mismatches and records the first.
// Each access is ISSUE (one cycle to raise mem, one cycle with mem high) then
// WAIT (first cycle ignores ready, then exits on the first ready=1).
module sram_test_seq
    import sram_test_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LAST_ADDR = 19'h7FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              mem,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_f2s,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_s2f_r,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act
);

    state_t            r_state;
    logic              r_issued;
    logic              r_waitFirst;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_seed;
    logic              r_mem;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dataF2s;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [15:0]       r_errCount;
    logic [ADDR_W-1:0] r_firstErrAddr;
    logic [DATA_W-1:0] r_firstErrExp;
    logic [DATA_W-1:0] r_firstErrAct;

    logic [ADDR_W-1:0] w_nextAddr;
    logic [ADDR_W-1:0] w_patAddr;
    logic [1:0]        w_patMode;
    logic [DATA_W-1:0] w_patSeed;
    logic [DATA_W-1:0] w_exp;
    logic              w_mismatch;
    logic              w_waitExit;

    assign w_nextAddr = r_addr + 19'd1;
    assign w_mismatch = (data_s2f_r != w_exp);
    assign w_waitExit = !r_waitFirst && ready;

    // One pattern generator serves three purposes: exp(0) from the live inputs
    // at start, exp(next address) when advancing the write pass, and
    // exp(current address) for the read-back compare.
    always_comb begin
        w_patMode = r_mode;
        w_patSeed = r_seed;
        w_patAddr = w_nextAddr;
        case (r_state)
            IDLE, DONE: begin
                w_patMode = mode;
                w_patSeed = seed;
                w_patAddr = '0;
            end
            RD_WAIT: w_patAddr = r_addr;
            default: ;
        endcase
    end

    sram_test_pattern u_pattern (
        .mode (w_patMode),
        .seed (w_patSeed),
        .addr (w_patAddr),
        .exp  (w_exp)
    );

    // Sequencer state machine with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_issued       <= 1'b0;
            r_waitFirst    <= 1'b0;
            r_mode         <= '0;
            r_seed         <= '0;
            r_mem          <= 1'b0;
            r_rw           <= 1'b1;
            r_addr         <= '0;
            r_dataF2s      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_errCount     <= '0;
            r_firstErrAddr <= '0;
            r_firstErrExp  <= '0;
            r_firstErrAct  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mode         <= mode;
                        r_seed         <= seed;
                        r_errCount     <= '0;
                        r_firstErrAddr <= '0;
                        r_firstErrExp  <= '0;
                        r_firstErrAct  <= '0;
                        r_addr         <= '0;
                        r_rw           <= 1'b0;
                        r_dataF2s      <= w_exp;
                        r_done         <= 1'b0;
                        r_pass         <= 1'b0;
                        r_busy         <= 1'b1;
                        r_issued       <= 1'b0;
                        r_state        <= WR_ISSUE;
                    end
                end
                WR_ISSUE, RD_ISSUE: begin
                    if (r_issued) begin
                        r_mem       <= 1'b0;
                        r_issued    <= 1'b0;
                        r_waitFirst <= 1'b1;
                        r_state     <= (r_state == WR_ISSUE) ? WR_WAIT : RD_WAIT;
                    end else if (ready) begin
                        r_mem    <= 1'b1;
                        r_issued <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    r_waitFirst <= 1'b0;
                    if (w_waitExit) begin
                        if (r_addr == LAST_ADDR) begin
                            r_addr  <= '0;
                            r_rw    <= 1'b1;
                            r_state <= RD_ISSUE;
                        end else begin
                            r_addr    <= w_nextAddr;
                            r_dataF2s <= w_exp;
                            r_state   <= WR_ISSUE;
                        end
                    end
                end
                RD_WAIT: begin
                    r_waitFirst <= 1'b0;
                    if (w_waitExit) begin
                        if (w_mismatch) begin
                            if (r_errCount != 16'hFFFF) begin
                                r_errCount <= r_errCount + 16'd1;
                            end
                            if (r_errCount == 16'd0) begin
                                r_firstErrAddr <= r_addr;
                                r_firstErrExp  <= w_exp;
                                r_firstErrAct  <= data_s2f_r;
                            end
                        end
                        if (r_addr == LAST_ADDR) begin
                            r_done  <= 1'b1;
                            r_pass  <= (r_errCount == 16'd0) && !w_mismatch;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_addr  <= w_nextAddr;
                            r_state <= RD_ISSUE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem            = r_mem;
    assign rw             = r_rw;
    assign addr           = r_addr;
    assign data_f2s       = r_dataF2s;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_errCount;
    assign first_err_addr = r_firstErrAddr;
    assign first_err_exp  = r_firstErrExp;
    assign first_err_act  = r_firstErrAct;

endmodule

// File: tb/tb_sram_test_seq.sv
// Bench for sram_test_seq: two instances (LAST_ADDR 3 and 15) each attached
// to a behavioural SRAM controller with configurable stalls and read faults.
module tb_sram_test_seq;

    logic        clk;
    logic        reset_n;
    logic        startV   [2];
    logic [1:0]  modeIn   [2];
    logic [7:0]  seedIn   [2];
    logic        readyV   [2];
    logic [7:0]  rdata    [2];

    logic        memS, rwS, busyS, doneS, passS;
    logic [18:0] addrS, feaS;
    logic [7:0]  wdataS, feeS, featS;
    logic [15:0] errS;
    logic        memB, rwB, busyB, doneB, passB;
    logic [18:0] addrB, feaB;
    logic [7:0]  wdataB, feeB, featB;
    logic [15:0] errB;

    logic        memV   [2];
    logic        rwV    [2];
    logic        busyV  [2];
    logic        doneV  [2];
    logic        passV  [2];
    logic [18:0] addrV  [2];
    logic [18:0] feaV   [2];
    logic [7:0]  wdataV [2];
    logic [7:0]  feeV   [2];
    logic [7:0]  featV  [2];
    logic [15:0] errV   [2];

    logic [7:0]  mdl       [2][16];
    logic [7:0]  faultMask [2][16];
    logic        stuck     [2];
    logic        clearMdl  [2];
    logic [1:0]  modeCfg   [2];
    logic [7:0]  seedCfg   [2];
    int          extraStall[2];
    int          stallCnt  [2];
    logic        prevMem   [2];
    int          pulseCnt  [2];
    int          protoErr  [2];
    int          pulseBase [2];
    int          lastAddr  [2];

    int assertCount = 0;
    int failCount   = 0;

    assign memV[0] = memS;     assign memV[1] = memB;
    assign rwV[0] = rwS;       assign rwV[1] = rwB;
    assign busyV[0] = busyS;   assign busyV[1] = busyB;
    assign doneV[0] = doneS;   assign doneV[1] = doneB;
    assign passV[0] = passS;   assign passV[1] = passB;
    assign addrV[0] = addrS;   assign addrV[1] = addrB;
    assign feaV[0] = feaS;     assign feaV[1] = feaB;
    assign wdataV[0] = wdataS; assign wdataV[1] = wdataB;
    assign feeV[0] = feeS;     assign feeV[1] = feeB;
    assign featV[0] = featS;   assign featV[1] = featB;
    assign errV[0] = errS;     assign errV[1] = errB;

    sram_test_seq #(.LAST_ADDR(19'd3)) u_dutSmall (
        .clk(clk), .reset_n(reset_n), .start(startV[0]), .mode(modeIn[0]),
        .seed(seedIn[0]), .mem(memS), .rw(rwS), .addr(addrS), .data_f2s(wdataS),
        .ready(readyV[0]), .data_s2f_r(rdata[0]), .busy(busyS), .done(doneS),
        .pass(passS), .err_count(errS), .first_err_addr(feaS),
        .first_err_exp(feeS), .first_err_act(featS)
    );

    sram_test_seq #(.LAST_ADDR(19'd15)) u_dutBig (
        .clk(clk), .reset_n(reset_n), .start(startV[1]), .mode(modeIn[1]),
        .seed(seedIn[1]), .mem(memB), .rw(rwB), .addr(addrB), .data_f2s(wdataB),
        .ready(readyV[1]), .data_s2f_r(rdata[1]), .busy(busyB), .done(doneB),
        .pass(passB), .err_count(errB), .first_err_addr(feaB),
        .first_err_exp(feeB), .first_err_act(featB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pattern: the byte that belongs at address a for a mode/seed.
    function automatic logic [7:0] refExp(input logic [1:0] m, input logic [7:0] s, input int a);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'(a % 256);
        hi = 8'((a / 256) % 256);
        case (m)
            2'd0:    return lo ^ s;
            2'd1:    return (((a % 2) == 1) ? 8'hAA : 8'h55) ^ s;
            2'd2:    return s;
            default: return ~(lo ^ hi) ^ s;
        endcase
    endfunction

    // Behavioural SRAM controllers: a request is taken on any edge where mem is
    // high; ready then drops for extraStall cycles; read data is registered
    // and optionally corrupted by the fault configuration.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < 2; g++) begin
                readyV[g]   <= 1'b1;
                stallCnt[g] <= 0;
                rdata[g]    <= '0;
                prevMem[g]  <= 1'b0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                prevMem[g] <= memV[g];
                if (clearMdl[g]) begin
                    for (int a = 0; a < 16; a++) mdl[g][a] <= ~refExp(modeCfg[g], seedCfg[g], a);
                end
                if (memV[g]) begin
                    pulseCnt[g] <= pulseCnt[g] + 1;
                    if (!readyV[g] || prevMem[g] || addrV[g] > 19'(lastAddr[g]))
                        protoErr[g] <= protoErr[g] + 1;
                    if (!rwV[g]) mdl[g][addrV[g][3:0]] <= wdataV[g];
                    else rdata[g] <= stuck[g] ? 8'h00 : (mdl[g][addrV[g][3:0]] ^ faultMask[g][addrV[g][3:0]]);
                    stallCnt[g] <= extraStall[g];
                    readyV[g]   <= (extraStall[g] == 0);
                end else if (stallCnt[g] != 0) begin
                    stallCnt[g] <= stallCnt[g] - 1;
                    readyV[g]   <= (stallCnt[g] == 1);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearFaults(input int g);
        for (int a = 0; a < 16; a++) faultMask[g][a] = 8'h00;
        stuck[g] = 1'b0;
    endtask

    // Start one run and wait for done; optionally pulse start again while busy.
    task automatic applyStimulus(input int g, input logic [1:0] m, input logic [7:0] s,
                                 input int extra, input int midStartAt, output int cycles);
        int limit;
        limit = 16 * (lastAddr[g] + 1) + 40;
        modeCfg[g]    = m;
        seedCfg[g]    = s;
        extraStall[g] = extra;
        clearMdl[g]   = 1'b1;
        @(posedge clk); #1;
        clearMdl[g]   = 1'b0;
        pulseBase[g]  = pulseCnt[g];
        startV[g]     = 1'b1;
        modeIn[g]     = m;
        seedIn[g]     = s;
        @(posedge clk); #1;
        startV[g]     = 1'b0;
        modeIn[g]     = ~m;
        seedIn[g]     = ~s;
        cycles = 0;
        while (!doneV[g] && cycles < limit) begin
            if (cycles == midStartAt) startV[g] = 1'b1;
            @(posedge clk); #1;
            startV[g] = 1'b0;
            cycles++;
        end
    endtask

    // Compare the end-of-run results and the memory image with the model.
    task automatic finishCheck(input int g, input logic [1:0] m, input logic [7:0] s, input int expErr,
                               input int fa, input logic [7:0] fe, input logic [7:0] fact);
        int bad;
        bad = 0;
        for (int a = 0; a <= lastAddr[g]; a++) if (mdl[g][a] !== refExp(m, s, a)) bad++;
        checkOutput("done", 32'(doneV[g]), 32'd1);
        checkOutput("busyAtDone", 32'(busyV[g]), 32'd0);
        checkOutput("pass", 32'(passV[g]), 32'(expErr == 0));
        checkOutput("errCount", 32'(errV[g]), 32'(expErr));
        checkOutput("firstErrAddr", 32'(feaV[g]), 32'(fa));
        checkOutput("firstErrExp", 32'(feeV[g]), 32'(fe));
        checkOutput("firstErrAct", 32'(featV[g]), 32'(fact));
        checkOutput("memImage", 32'(bad), 32'd0);
        checkOutput("memPulses", 32'(pulseCnt[g] - pulseBase[g]), 32'(2 * (lastAddr[g] + 1)));
        checkOutput("protocol", 32'(protoErr[g]), 32'd0);
    endtask

    initial begin
        int cyc;
        int nf;
        int minA;
        int fAddr;
        int nErr;
        int waitCyc;
        logic [1:0] m;
        logic [7:0] s;
        logic [7:0] e;
        int extra;

        lastAddr[0] = 3;
        lastAddr[1] = 15;
        for (int g = 0; g < 2; g++) begin
            startV[g] = 1'b0; modeIn[g] = '0; seedIn[g] = '0;
            clearMdl[g] = 1'b0; modeCfg[g] = '0; seedCfg[g] = '0;
            extraStall[g] = 0; pulseBase[g] = 0;
            clearFaults(g);
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            checkOutput("rstMem", 32'(memV[g]), 32'd0);
            checkOutput("rstRw", 32'(rwV[g]), 32'd1);
            checkOutput("rstAddr", 32'(addrV[g]), 32'd0);
            checkOutput("rstData", 32'(wdataV[g]), 32'd0);
            checkOutput("rstFlags", {29'd0, busyV[g], doneV[g], passV[g]}, 32'd0);
            checkOutput("rstErr", 32'(errV[g]) | 32'(feaV[g]) | 32'(feeV[g]) | 32'(featV[g]), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] ideal memory, mode 0, seed 00");
        applyStimulus(0, 2'd0, 8'h00, 0, -1, cyc);
        checkOutput("doneCycle", 32'(cyc), 32'd32);
        for (int a = 0; a < 4; a++) checkOutput("writeData", 32'(mdl[0][a]), 32'(a));
        finishCheck(0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00);

        $display("[TB] bit 0 flipped on read of address 2");
        faultMask[0][2] = 8'h01;
        applyStimulus(0, 2'd0, 8'h00, 0, -1, cyc);
        finishCheck(0, 2'd0, 8'h00, 1, 2, 8'h02, 8'h03);
        clearFaults(0);

        $display("[TB] mode 2 seed FF, reads stuck at 00");
        stuck[1] = 1'b1;
        applyStimulus(1, 2'd2, 8'hFF, 0, -1, cyc);
        checkOutput("doneCycleBig", 32'(cyc), 32'd128);
        finishCheck(1, 2'd2, 8'hFF, 16, 0, 8'hFF, 8'h00);
        clearFaults(1);

        $display("[TB] mode 1 seed 00 with 3 stall cycles per access");
        applyStimulus(0, 2'd1, 8'h00, 3, -1, cyc);
        checkOutput("checker0", 32'(mdl[0][0]), 32'h55);
        checkOutput("checker1", 32'(mdl[0][1]), 32'hAA);
        finishCheck(0, 2'd1, 8'h00, 0, 0, 8'h00, 8'h00);

        $display("[TB] start pulsed while busy");
        applyStimulus(1, 2'd3, 8'h3C, 0, 10, cyc);
        checkOutput("busyStartCycle", 32'(cyc), 32'd128);
        finishCheck(1, 2'd3, 8'h3C, 0, 0, 8'h00, 8'h00);

        $display("[TB] randomized runs");
        for (int iter = 0; iter < 4; iter++) begin
            m = 2'($urandom_range(0, 3));
            s = 8'($urandom);
            extra = $urandom_range(0, 3);
            clearFaults(1);
            nf = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++) begin
                fAddr = $urandom_range(0, 15);
                faultMask[1][fAddr] = 8'($urandom_range(1, 255));
            end
            nErr = 0;
            minA = 0;
            for (int a = 15; a >= 0; a--) if (faultMask[1][a] != 8'h00) begin nErr++; minA = a; end
            e = (nErr > 0) ? refExp(m, s, minA) : 8'h00;
            applyStimulus(1, m, s, extra, -1, cyc);
            if (nErr > 0) finishCheck(1, m, s, nErr, minA, e, e ^ faultMask[1][minA]);
            else          finishCheck(1, m, s, 0, 0, 8'h00, 8'h00);
        end
        clearFaults(1);

        $display("[TB] reset during read pass");
        modeCfg[1] = 2'd0; seedCfg[1] = 8'h11; extraStall[1] = 1;
        clearMdl[1] = 1'b1;
        @(posedge clk); #1;
        clearMdl[1] = 1'b0;
        startV[1] = 1'b1; modeIn[1] = 2'd0; seedIn[1] = 8'h11;
        @(posedge clk); #1;
        startV[1] = 1'b0;
        waitCyc = 0;
        while (!(rwV[1] && busyV[1] && memV[1]) && waitCyc < 400) begin
            @(posedge clk); #1;
            waitCyc++;
        end
        checkOutput("reachedReadPass", 32'(waitCyc < 400), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rstMidMem", 32'(memV[1]), 32'd0);
        checkOutput("rstMidBusy", 32'(busyV[1]), 32'd0);
        pulseBase[1] = pulseCnt[1];
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstNoPulse", 32'(pulseCnt[1] - pulseBase[1]), 32'd0);
        checkOutput("rstDone", 32'(doneV[1]), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 2'd1, 8'hC3, 0, -1, cyc);
        checkOutput("afterRstCycle", 32'(cyc), 32'd128);
        finishCheck(1, 2'd1, 8'hC3, 0, 0, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_test_seq.md
SRAM_TEST_SEQ -- requirements
Module: sram_test_seq

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 19'h7FFFF: final address tested; the test covers addresses 0..LAST_ADDR.
REQ-002 SHALL have port clk, input, 1: single clock, shared with the SRAM controller.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a test.
REQ-005 SHALL have port mode, input, 2: pattern select, sampled at start.
REQ-006 SHALL have port seed, input, 8: pattern seed, sampled at start.
REQ-007 SHALL have port mem, output, 1: access request to the SRAM controller.
REQ-008 SHALL have port rw, output, 1: 1 = read, 0 = write.
REQ-009 SHALL have port addr, output, 19: access address.
REQ-010 SHALL have port data_f2s, output, 8: write data.
REQ-011 SHALL have port ready, input, 1: controller idle and able to accept a request.
REQ-012 SHALL have port data_s2f_r, input, 8: registered read data from the controller.
REQ-013 SHALL have port busy, output, 1: test in progress.
REQ-014 SHALL have port done, output, 1: test complete; held high until the next start.
REQ-015 SHALL have port pass, output, 1: done and zero errors.
REQ-016 SHALL have port err_count, output, 16: mismatch count, saturating.
REQ-017 SHALL have ports first_err_addr (19 bits), first_err_exp (8 bits) and first_err_act (8 bits), all outputs: details of the first mismatch.

Function
REQ-018 SHALL use states IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE.
REQ-019 SHALL, on start in IDLE or DONE, latch mode and seed, clear the count and first-error outputs, set addr to 0, clear done, and enter WR_ISSUE.
REQ-020 SHALL ignore start in every other state.
REQ-021 SHALL assert mem only in the ISSUE states, for exactly one cycle, and only with ready=1; an ISSUE state SHALL hold while ready=0.
REQ-022 SHALL hold addr, rw and data_f2s stable from ISSUE through the end of the following WAIT.
REQ-023 SHALL ignore ready in the first WAIT cycle, then leave WAIT on the first cycle with ready=1; any number of ready=0 stall cycles SHALL be tolerated.
REQ-024 SHALL define the expected data exp(addr) as: mode 0 = addr[7:0]^seed; mode 1 = (addr[0] ? 8'hAA : 8'h55)^seed; mode 2 = seed; mode 3 = ~(addr[7:0]^addr[15:8])^seed.
REQ-025 SHALL, in the write pass, write exp(addr) with rw=0; leaving WR_WAIT at LAST_ADDR SHALL reset addr to 0 and enter RD_ISSUE, otherwise addr increments and the next state is WR_ISSUE.
REQ-026 SHALL, in the read pass, issue rw=1 and compare data_s2f_r with exp(addr) in the RD_WAIT exit cycle.
REQ-027 SHALL, on a mismatch, increment err_count, saturating at 16'hFFFF.
REQ-028 SHALL capture first_err_* only when err_count was 0 before the mismatch.
REQ-029 SHALL, on leaving RD_WAIT at LAST_ADDR, enter DONE; DONE sets done=1 and pass=(err_count==0).
REQ-030 SHALL take 4 cycles per access with a zero-stall controller; total run length SHALL be 8*(LAST_ADDR+1) cycles from the start edge to done=1.
REQ-031 SHALL compute the address increment in 19 bits; LAST_ADDR=19'h7FFFF SHALL terminate without wrapping.
REQ-032 SHALL drive busy=1 in every state except IDLE and DONE.

Reset
REQ-033 SHALL, while reset_n=0, force IDLE, mem=0, rw=1, addr=0, data_f2s=0, busy=0, done=0, pass=0, err_count=0 and first_err_*=0.
REQ-034 SHALL, on reset assertion mid-test, abandon the test with no further mem pulse; the SRAM controller shares reset_n.

Structure
REQ-035 SHALL place state encodings, mode constants and the address/data widths in shared package sram_test_pkg.
REQ-036 SHALL implement exp(addr) in combinational sub-module sram_test_pattern (inputs mode, seed, addr; output exp).
REQ-037 SHALL register all controller-facing outputs.

Verification
REQ-038 SHALL cover: LAST_ADDR=3, mode 0, seed 8'h00, ideal memory model -> writes 00,01,02,03 to addresses 0..3; done at cycle 32; pass=1; err_count=0.
REQ-039 SHALL cover: the same setup with the model flipping bit 0 at address 2 -> err_count=1, first_err_addr=2, first_err_exp=8'h02, first_err_act=8'h03, pass=0.
REQ-040 SHALL cover: LAST_ADDR=15, mode 2, seed 8'hFF, model reads stuck at 8'h00 -> err_count=16, first_err_addr=0.
REQ-041 SHALL cover: mode 1, seed 8'h00, model inserting 3 extra ready=0 cycles per access -> data 55/AA alternating, exactly one mem pulse per access, pass=1.
REQ-042 SHALL cover: start pulsed while busy -> no effect; reset_n low during the read pass -> mem=0 and busy=0 immediately; a new start then runs to pass=1.
